// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream packet reader.
package fifo_stream_pkg;

    localparam int unsigned PKT_LEN_DEF = 8;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned OCC_W       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Modulo counter step that wraps to zero after the given last index.
    function automatic logic [CNT_W-1:0] cnt_wrap(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] last
    );
        return (cnt == last) ? '0 : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order word buffer; the head entry drives the stream output.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] head,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic              w_push;
    logic              w_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_pop  = pop & (r_occ != '0);
    assign w_push = push & ((r_occ != OCC_W'(2)) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign head = r_mem[r_rd_ptr];
    assign occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads fixed-length packets from a 1-cycle-latency FIFO and presents them as a
// valid/ready stream with last marking and a completed-packet counter.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PKT_LEN = PKT_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              enable,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [15:0]       pkt_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

    rd_state_e         r_state;
    rd_state_e         w_state_nxt;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [CNT_W-1:0]  r_iss_cnt;
    logic [15:0]       r_pkt_count;

    logic [OCC_W-1:0]  w_occ;
    logic [DATA_W-1:0] w_head;
    logic              w_valid;
    logic              w_xfer;
    logic              w_last;
    logic              w_busy;
    logic              w_allow;
    logic              w_rd_en;
    logic [2:0]        w_level;

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .pop   (w_xfer),
        .data  (fifo_data),
        .head  (w_head),
        .occ   (w_occ)
    );

    assign w_valid = (w_occ != '0);
    assign w_xfer  = w_valid & m_ready;
    assign w_last  = w_valid & (r_out_cnt == LAST_IDX);
    assign w_busy  = r_inflight | w_valid;

    // Words already owned (buffered or in flight) after this edge must stay within two.
    assign w_level = 3'(w_occ) + 3'(r_inflight) - 3'(w_xfer);
    assign w_rd_en = w_allow & ~fifo_empty & (w_level < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping enable mid-packet keeps issuing reads until the packet is complete.
    always_comb begin
        w_state_nxt = r_state;
        w_allow     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_allow = 1'b1;
                if (!enable) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_allow = (r_iss_cnt != '0);
                if (enable) begin
                    w_state_nxt = RUN;
                end else if ((r_iss_cnt == '0) && !w_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= 1'b0;
            r_iss_cnt   <= '0;
            r_out_cnt   <= '0;
            r_pkt_count <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_iss_cnt <= cnt_wrap(r_iss_cnt, LAST_IDX);
            end
            if (w_xfer) begin
                r_out_cnt <= cnt_wrap(r_out_cnt, LAST_IDX);
            end
            if (w_xfer && w_last) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_data     = w_head;
    assign m_valid    = w_valid;
    assign m_last     = w_last;
    assign pkt_count  = r_pkt_count;
    assign busy       = w_busy;

endmodule
